// File: rtl/multiplier_controller_taint_track_1bit_pkg.sv
// Shared state encoding, control-bundle type and output decode for the
// taint-tracked shift-add multiplier controller.
package mult_pkg;

  localparam int MULT_DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } mult_ctrl_state_e;

  typedef struct packed {
    logic rsclear;
    logic mrld;
    logic mdld;
    logic rsload;
    logic rsshr;
    logic done;
  } mult_ctrl_t;

  // Moore decode: each state owns a fixed set of datapath strobes.
  function automatic mult_ctrl_t ctrl_decode(input mult_ctrl_state_e s);
    mult_ctrl_t c;
    c = '{rsclear: 1'b0, mrld: 1'b0, mdld: 1'b0, rsload: 1'b0, rsshr: 1'b0, done: 1'b0};
    case (s)
      INIT: begin
        c.rsclear = 1'b1;
        c.mrld    = 1'b1;
        c.mdld    = 1'b1;
      end
      ADD:     c.rsload = 1'b1;
      SHIFT:   c.rsshr  = 1'b1;
      DONE:    c.done   = 1'b1;
      default: c.done   = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multiplier_controller_taint_track_1bit_counter.sv
// Bit-position counter for the multiplier controller; last flags the final
// multiplier bit so the FSM never lets the count wrap.
module mult_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  // Count register: clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      count_q <= {CNT_W{1'b0}};
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_controller_taint_track_1bit.sv
// Control FSM for the 1-bit taint-tracked shift-add multiplier.
// Optional build macro MULT_CTRL_TAINT_CLEAR_EN drops the sticky taint when DONE returns to IDLE.
module multiplier_controller_taint_track_1bit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             rsclear,
  output logic             mrld,
  output logic             mdld,
  output logic             rsload,
  output logic             rsshr,
  output logic             rsclear_t,
  output logic             mrld_t,
  output logic             mdld_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             done,
  output logic             done_t
);

  localparam int CNT_W = $clog2(WIDTH);

  mult_ctrl_state_e state_q, state_d;
  logic             state_t_q, state_t_d;
  mult_ctrl_t       ctrl_q;
  logic             cnt_clear_s;
  logic             cnt_inc_s;
  logic [CNT_W-1:0] count_s;
  logic             last_s;

  mult_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear_s),
    .inc_i   (cnt_inc_s),
    .count_o (count_s),
    .last_o  (last_s)
  );

  // Next state and taint: taint absorbs every input that steered a branch.
  always_comb begin
    state_d     = state_q;
    state_t_d   = state_t_q;
    cnt_clear_s = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        state_t_d = state_t_q | start_t;
        if (start) begin
          state_d = INIT;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        cnt_clear_s = 1'b1;
        state_d     = CHECK;
      end
      CHECK: begin
        state_t_d = state_t_q | multiplierReg_t;
        if (multiplierReg[count_s]) begin
          state_d = ADD;
        end else begin
          state_d = SHIFT;
        end
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          cnt_inc_s = 1'b1;
          state_d   = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MULT_CTRL_TAINT_CLEAR_EN
        state_t_d = 1'b0;
`else
        state_t_d = state_t_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, taint and strobes registered together so outputs track the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      state_t_q <= 1'b0;
      ctrl_q    <= ctrl_decode(IDLE);
    end else begin
      state_q   <= state_d;
      state_t_q <= state_t_d;
      ctrl_q    <= ctrl_decode(state_d);
    end
  end

  assign rsclear   = ctrl_q.rsclear;
  assign mrld      = ctrl_q.mrld;
  assign mdld      = ctrl_q.mdld;
  assign rsload    = ctrl_q.rsload;
  assign rsshr     = ctrl_q.rsshr;
  assign done      = ctrl_q.done;
  assign rsclear_t = state_t_q;
  assign mrld_t    = state_t_q;
  assign mdld_t    = state_t_q;
  assign rsload_t  = state_t_q;
  assign rsshr_t   = state_t_q;
  assign done_t    = state_t_q;

endmodule

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
// Self-checking bench: a plan-queue model of the multiply schedule and taint
// rules is compared every cycle, plus directed latency/product/taint checks.
module tb_multiplier_controller_taint_track_1bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic [W-1:0] multiplierReg = '0;
  logic         multiplierReg_t = 1'b0;
  logic rsclear, mrld, mdld, rsload, rsshr, done;
  logic rsclear_t, mrld_t, mdld_t, rsload_t, rsshr_t, done_t;

  int total = 0;
  int bad   = 0;

  multiplier_controller_taint_track_1bit #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .start_t         (start_t),
    .multiplierReg   (multiplierReg),
    .multiplierReg_t (multiplierReg_t),
    .rsclear         (rsclear),
    .mrld            (mrld),
    .mdld            (mdld),
    .rsload          (rsload),
    .rsshr           (rsshr),
    .rsclear_t       (rsclear_t),
    .mrld_t          (mrld_t),
    .mdld_t          (mdld_t),
    .rsload_t        (rsload_t),
    .rsshr_t         (rsshr_t),
    .done            (done),
    .done_t          (done_t)
  );

  always #5 clk = ~clk;

  // Model: a queue of planned cycles; vec = {rsclear,mrld,mdld,rsload,rsshr,done}.
  typedef struct {
    logic [5:0] vec;
    int         chk;   // multiplier bit examined in this cycle, -1 if none
  } step_t;

  localparam logic [5:0] V_INIT  = 6'b111000;
  localparam logic [5:0] V_ADD   = 6'b000100;
  localparam logic [5:0] V_SHIFT = 6'b000010;
  localparam logic [5:0] V_DONE  = 6'b000001;

  step_t plan[$];
  step_t cur = '{vec: 6'b0, chk: -1};
  bit    busy = 1'b0;
  logic  m_taint = 1'b0;

  task automatic model_edge();
    step_t s;
    if (!rst_n) begin
      plan.delete();
      busy    = 1'b0;
      m_taint = 1'b0;
      cur     = '{vec: 6'b0, chk: -1};
    end else if (!busy) begin
      m_taint = m_taint | start_t;
      if (start) begin
        plan.delete();
        for (int i = 0; i < W; i++) begin
          s = '{vec: 6'b0, chk: i};
          plan.push_back(s);
          s = '{vec: V_SHIFT, chk: -1};
          plan.push_back(s);
        end
        s = '{vec: V_DONE, chk: -1};
        plan.push_back(s);
        cur  = '{vec: V_INIT, chk: -1};
        busy = 1'b1;
      end
    end else begin
      if (cur.chk >= 0) begin
        m_taint = m_taint | multiplierReg_t;
        if (multiplierReg[cur.chk]) begin
          s = '{vec: V_ADD, chk: -1};
          plan.push_front(s);
        end
      end
      if (cur.vec[0]) begin
`ifdef MULT_CTRL_TAINT_CLEAR_EN
        m_taint = 1'b0;
`endif
        busy = 1'b0;
        cur  = '{vec: 6'b0, chk: -1};
      end else begin
        cur = plan.pop_front();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic compare();
    logic [5:0] got, got_t;
    got   = {rsclear, mrld, mdld, rsload, rsshr, done};
    got_t = {rsclear_t, mrld_t, mdld_t, rsload_t, rsshr_t, done_t};
    total++;
    if (got !== cur.vec || got_t !== {6{m_taint}}) begin
      bad++;
      $display("FAIL cycle @%0t: ctrl=%b taint=%b expected ctrl=%b taint=%b",
               $time, got, got_t, cur.vec, {6{m_taint}});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    rst_n = 1'b1;
    start = 1'b0;
    start_t = 1'b0;
    multiplierReg_t = 1'b0;
  endtask

  // Runs one multiply; cycle 1 is the first cycle after the start edge.
  task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] mcand, input bit taint1,
                        output int done_cyc, output int n_ld, output int n_sh,
                        output logic [2*W-1:0] prod, output logic t3, output logic dt);
    logic [2*W:0] rs;
    logic [W-1:0] md;
    int k;
    rs = '0; md = '0; done_cyc = -1; n_ld = 0; n_sh = 0; t3 = 1'bx; dt = 1'bx;
    multiplierReg = mr;
    start = 1'b1;
    cyc();
    start = 1'b0;
    multiplierReg_t = taint1;
    k = 1;
    while (k < 60) begin
      if (k == 3) t3 = rsshr_t;
      if (rsclear) rs = '0;
      if (mdld) md = mcand;
      if (rsload) begin
        rs[2*W:W] = rs[2*W:W] + {1'b0, md};
        n_ld++;
      end
      if (rsshr) begin
        rs = rs >> 1;
        n_sh++;
      end
      if (done) begin
        done_cyc = k;
        dt = done_t;
        break;
      end
      cyc();
      k++;
    end
    prod = rs[2*W-1:0];
  endtask

  int dc, nl, ns;
  logic [2*W-1:0] pr;
  logic t3v, dtv;
  bit add_seen;

  initial begin
    // Reset held with start high: nothing may leave IDLE.
    do_reset(2);
    chk("reset_ctrl", {26'd0, rsclear, mrld, mdld, rsload, rsshr, done}, 32'd0);
    chk("reset_taint", {26'd0, rsclear_t, mrld_t, mdld_t, rsload_t, rsshr_t, done_t}, 32'd0);
    cyc();
    chk("post_reset_no_init", {31'd0, rsclear}, 32'd0);

    run_op(4'b0000, 4'd3, 1'b0, dc, nl, ns, pr, t3v, dtv);
    chk("m0_done_cycle", dc, 32'd10);
    chk("m0_rsshr_count", ns, 32'd4);
    chk("m0_rsload_count", nl, 32'd0);
    chk("m0_done_t", {31'd0, dtv}, 32'd0);
    cyc();

    run_op(4'b1011, 4'd5, 1'b0, dc, nl, ns, pr, t3v, dtv);
    chk("m11_done_cycle", dc, 32'd13);
    chk("m11_rsload_count", nl, 32'd3);
    chk("m11_rsshr_count", ns, 32'd4);
    chk("m11_product", {24'd0, pr}, 32'd55);
    chk("m11_done_t", {31'd0, dtv}, 32'd0);
    cyc();

    // Tainted start that does not start still taints the controller.
    start_t = 1'b1;
    cyc();
    start_t = 1'b0;
    chk("idle_taint_t", {31'd0, done_t}, 32'd1);
    chk("idle_taint_ctrl", {26'd0, rsclear, mrld, mdld, rsload, rsshr, done}, 32'd0);
    cyc();

    // Reset in the middle of an ADD.
    do_reset(1);
    multiplierReg = 4'b0011;
    start = 1'b1;
    cyc();
    start = 1'b0;
    add_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsload) begin
        add_seen = 1'b1;
        break;
      end
      cyc();
    end
    chk("midop_add_reached", {31'd0, add_seen}, 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midop_reset_ctrl", {26'd0, rsclear, mrld, mdld, rsload, rsshr, done}, 32'd0);
    cyc();
    chk("midop_reset_no_pulse", {26'd0, rsclear, mrld, mdld, rsload, rsshr, done}, 32'd0);
    run_op(4'b0011, 4'd7, 1'b0, dc, nl, ns, pr, t3v, dtv);
    chk("m3_done_cycle", dc, 32'd12);
    chk("m3_product", {24'd0, pr}, 32'd21);

    // Tainted multiplier: taint visible from cycle 3, then macro-dependent in IDLE.
    do_reset(1);
    run_op(4'b0001, 4'd2, 1'b1, dc, nl, ns, pr, t3v, dtv);
    chk("taint_cycle3", {31'd0, t3v}, 32'd1);
    chk("taint_done_t", {31'd0, dtv}, 32'd1);
    chk("taint_done_cycle", dc, 32'd11);
    multiplierReg_t = 1'b0;
    cyc();
`ifdef MULT_CTRL_TAINT_CLEAR_EN
    chk("taint_after_done", {31'd0, rsclear_t}, 32'd0);
`else
    chk("taint_after_done", {31'd0, rsclear_t}, 32'd1);
`endif

    // Randomized traffic against the model.
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      rst_n           = ($urandom_range(0, 59) != 0);
      start           = ($urandom_range(0, 3) == 0);
      start_t         = ($urandom_range(0, 24) == 0);
      multiplierReg   = W'($urandom);
      multiplierReg_t = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
